i2s_master_t: RTL and testbench

- I2S transmitter for the SID audio path. Takes one signed 16-bit mono sample and serialises it to an external I2S DAC (PCM5102-class).
- Generates the master clock SCK, the bit clock BCK, the word clock LCK and the data line DIN from the 12 MHz system clock.
- Sends the same sample on the left and right channels.
- Pulses SAMPLED once per frame, when a new input sample is captured.

---
 rtl/i2s_master_t.sv | 80 ++++++++
 tb/tb_i2s_master_t.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/i2s_master_t.sv
// I2S master: serialises one mono sample to both channels with SCK/BCK/LCK/DIN all registered.
// Define LJ_FORMAT_EN for left-justified framing (no one-bit delay, LCK high = left).
module i2s_master_t #(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_BITS  = 32,
  parameter int BCK_DIV    = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [DATA_WIDTH-1:0] SMP,
  output logic                  SCK,
  output logic                  BCK,
  output logic                  DIN,
  output logic                  LCK,
  output logic                  SAMPLED
);

  localparam int FRAME = 2 * SLOT_BITS * BCK_DIV;
  localparam int CW    = $clog2(FRAME);

`ifdef LJ_FORMAT_EN
  localparam logic LCK_RST = 1'b1;
`else
  localparam logic LCK_RST = 1'b0;
`endif

  logic [CW-1:0]         c_q, c_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d, mask;
  logic                  wrap, sck_d, bck_d, din_d, lck_d;
  int unsigned           cnt, p, s, ch;

  // Outputs are decoded from the next count so every pin is a plain flop.
  always_comb begin
    c_d    = (c_q == CW'(FRAME - 1)) ? '0 : c_q + CW'(1);
    wrap   = (c_q == CW'(FRAME - 1));
    hold_d = wrap ? SMP : hold_q;
    cnt    = 32'(c_d);
    p      = cnt % BCK_DIV;
    s      = (cnt / BCK_DIV) % SLOT_BITS;
    ch     = cnt / (SLOT_BITS * BCK_DIV);
    sck_d  = c_d[0];
    bck_d  = (p >= BCK_DIV / 2);
    mask   = '0;
    din_d  = 1'b0;
`ifdef LJ_FORMAT_EN
    lck_d = (ch == 0);
    if (s < DATA_WIDTH) begin
      mask  = DATA_WIDTH'(1) << (DATA_WIDTH - 1 - s);
      din_d = |(hold_d & mask);
    end
`else
    lck_d = (ch != 0);
    if (s >= 1 && s <= DATA_WIDTH) begin
      mask  = DATA_WIDTH'(1) << (DATA_WIDTH - s);
      din_d = |(hold_d & mask);
    end
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      c_q     <= '0;
      hold_q  <= '0;
      SCK     <= 1'b0;
      BCK     <= 1'b0;
      LCK     <= LCK_RST;
      DIN     <= 1'b0;
      SAMPLED <= 1'b0;
    end else begin
      c_q     <= c_d;
      hold_q  <= hold_d;
      SCK     <= sck_d;
      BCK     <= bck_d;
      LCK     <= lck_d;
      DIN     <= din_d;
      SAMPLED <= wrap;
    end
  end

endmodule

// File: tb/tb_i2s_master_t.sv
// Bench for i2s_master_t: frame-level model checked every cycle plus literal per-frame word checks.
module tb_i2s_master_t;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [15:0] SMP;
  logic        SCK, BCK, DIN, LCK, SAMPLED;

  i2s_master_t #(.DATA_WIDTH(16), .SLOT_BITS(32), .BCK_DIV(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .SMP(SMP), .SCK(SCK), .BCK(BCK),
    .DIN(DIN), .LCK(LCK), .SAMPLED(SAMPLED)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Model: position in frame, the sample latched at the last wrap, and the strobe.
  logic [8:0]  k_m = '0;
  logic [15:0] hold_m = '0;
  logic        samp_m = 1'b0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      k_m <= '0; hold_m <= '0; samp_m <= 1'b0;
    end else begin
      k_m    <= k_m + 9'd1;
      samp_m <= (k_m == 9'd511);
      if (k_m == 9'd511) hold_m <= SMP;
    end
  end

  function automatic logic [4:0] model_out();
    int s = (int'(k_m) / 8) % 32;
    logic ch = (k_m >= 9'd256);
    logic [31:0] sw;
    logic lck;
`ifdef LJ_FORMAT_EN
    sw  = {hold_m, 16'h0000};
    lck = ~ch;
`else
    sw  = {1'b0, hold_m, 15'h0000};
    lck = ch;
`endif
    return {k_m[0], (int'(k_m) % 8) >= 4, lck, sw[31 - s], samp_m};
  endfunction

  // Per-cycle compare, timing checks and slot capture (word bit 31 = slot 0).
  logic [31:0] wl = '0, wr = '0, fl, fr;
  int          frame_cnt = 0;
  int          din_stable = 0;
  logic        prev_bck = 1'b0, prev_lck = 1'b0, prev_din = 1'b0, run_prev = 1'b0;

  always @(negedge CLK) begin
    check("cycle{SCK,BCK,LCK,DIN,SAMPLED}", {27'd0, SCK, BCK, LCK, DIN, SAMPLED},
          {27'd0, model_out()});
    din_stable = (DIN !== prev_din) ? 1 : din_stable + 1;
    if (RST_N && run_prev) begin
      if (!prev_bck && BCK) check("din_setup_ok", {31'd0, din_stable >= 4}, 32'd1);
      if (LCK !== prev_lck) check("lck_on_bck_fall", {30'd0, prev_bck, BCK}, 32'd2);
    end
    if (!RST_N || k_m == 9'd0) begin wl = '0; wr = '0; end
    if (RST_N && (k_m % 8) == 4) begin
      if (k_m < 9'd256) wl[31 - (int'(k_m) / 8)] = DIN;
      else              wr[31 - ((int'(k_m) - 256) / 8)] = DIN;
    end
    if (RST_N && k_m == 9'd511) begin fl = wl; fr = wr; frame_cnt++; end
    prev_bck = BCK; prev_lck = LCK; prev_din = DIN; run_prev = RST_N;
  end

  task automatic wait_frame(input string name);
    int start = frame_cnt;
    bit done = 0;
    for (int i = 0; i < 1100 && !done; i++) begin
      @(negedge CLK); #1;
      if (frame_cnt != start) done = 1;
    end
    if (!done) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_k(input int k);
    bit done = 0;
    for (int i = 0; i < 1100 && !done; i++) begin
      @(negedge CLK); #1;
      if (int'(k_m) == k) done = 1;
    end
    if (!done) check("wait_k_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_frame(input string name, input logic [31:0] exp);
    check({name, "_left"}, fl, exp);
    check({name, "_right"}, fr, exp);
  endtask

`ifdef LJ_FORMAT_EN
  localparam logic [4:0]  RST_OUT = 5'b00100;
  localparam logic [31:0] W_A5C3 = 32'hA5C30000, W_0001 = 32'h00010000, W_8000 = 32'h80000000;
`else
  localparam logic [4:0]  RST_OUT = 5'b00000;
  localparam logic [31:0] W_A5C3 = 32'h52E18000, W_0001 = 32'h00008000, W_8000 = 32'h40000000;
`endif

  initial begin
    RST_N = 1'b1;
    SMP   = 16'h7FFF;
    #1 RST_N = 1'b0;
    repeat (5) @(negedge CLK);
    #1;
    check("reset_outputs", {27'd0, SCK, BCK, LCK, DIN, SAMPLED}, {27'd0, RST_OUT});
    RST_N = 1'b1;

    wait_k(100);
    SMP = 16'hA5C3;
    wait_frame("f1");
    check_frame("first_frame_zero", 32'h0);

    wait_k(100);
    SMP = 16'h0001;
    wait_frame("f2");
    check_frame("a5c3_frame", W_A5C3);

    wait_k(100);
    SMP = 16'h8000;
    wait_frame("f3");
    check_frame("lsb_only_frame", W_0001);

    wait_frame("f4");
    check_frame("neg_full_scale", W_8000);

    wait_k(205);
    RST_N = 1'b0;
    #1;
    check("async_reset_clear", {27'd0, SCK, BCK, LCK, DIN, SAMPLED}, {27'd0, RST_OUT});
    @(negedge CLK); #1;
    RST_N = 1'b1;
    wait_frame("f5");
    check_frame("post_reset_zero", 32'h0);
    wait_frame("f6");
    check_frame("post_reset_resume", W_8000);

    repeat (4) @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
